// File: rtl/e_muldiv_unit.sv
// EX-stage multiply/divide unit holding the architectural HI/LO registers.
// Optional build macro MULDIV_MADD_EN enables MADD/MADDU (ops 7/8) accumulation into {hi,lo}.
module e_muldiv_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        rd_hi,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] hilo_out
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = ($clog2(MAX_CYCLES) > 4) ? $clog2(MAX_CYCLES) : 4;

    localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_CYCLES - 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MULDIV_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
`endif

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [63:0]       pend, pend_n;
    logic              pend_wr, pend_wr_n;
    logic [31:0]       hi_n, lo_n;

    // ------------------------------------------------------------------
    // Datapath: every result is formed combinationally from the operands
    // present at the start edge and parked in the pending register.
    // ------------------------------------------------------------------
    logic [63:0] prod_s, prod_u;
    assign prod_s = $signed({{32{rs_data[31]}}, rs_data}) * $signed({{32{rt_data[31]}}, rt_data});
    assign prod_u = {32'b0, rs_data} * {32'b0, rt_data};

    // Signed divide runs on magnitudes so 0x80000000 / -1 never overflows.
    logic        rs_neg, rt_neg, div_zero, is_sdiv;
    logic [31:0] rs_mag, rt_mag, div_a, div_b, div_den;
    logic [31:0] quo, rem, quo_s, rem_s;

    assign rs_neg   = rs_data[31];
    assign rt_neg   = rt_data[31];
    assign rs_mag   = rs_neg ? (~rs_data + 32'd1) : rs_data;
    assign rt_mag   = rt_neg ? (~rt_data + 32'd1) : rt_data;
    assign is_sdiv  = (op == OP_DIV);
    assign div_a    = is_sdiv ? rs_mag : rs_data;
    assign div_b    = is_sdiv ? rt_mag : rt_data;
    assign div_zero = (rt_data == 32'd0);
    assign div_den  = div_zero ? 32'd1 : div_b;
    assign quo      = div_a / div_den;
    assign rem      = div_a % div_den;
    assign quo_s    = (is_sdiv && (rs_neg ^ rt_neg)) ? (~quo + 32'd1) : quo;
    assign rem_s    = (is_sdiv && rs_neg) ? (~rem + 32'd1) : rem;

`ifdef MULDIV_MADD_EN
    logic [63:0] madd_s, madd_u;
    assign madd_s = {hi, lo} + prod_s;
    assign madd_u = {hi, lo} + prod_u;
`endif

    // ------------------------------------------------------------------
    // Next-state / next-value logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_n   = state;
        cnt_n     = cnt;
        pend_n    = pend;
        pend_wr_n = pend_wr;
        hi_n      = hi;
        lo_n      = lo;

        case (state)
            IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT: begin
                            pend_n    = prod_s;
                            pend_wr_n = 1'b1;
                            cnt_n     = MULT_LAST;
                            state_n   = RUN;
                        end
                        OP_MULTU: begin
                            pend_n    = prod_u;
                            pend_wr_n = 1'b1;
                            cnt_n     = MULT_LAST;
                            state_n   = RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            // A zero divisor still occupies the unit but never commits.
                            pend_n    = {rem_s, quo_s};
                            pend_wr_n = ~div_zero;
                            cnt_n     = DIV_LAST;
                            state_n   = RUN;
                        end
                        OP_MTHI: hi_n = rs_data;
                        OP_MTLO: lo_n = rs_data;
`ifdef MULDIV_MADD_EN
                        OP_MADD: begin
                            pend_n    = madd_s;
                            pend_wr_n = 1'b1;
                            cnt_n     = MULT_LAST;
                            state_n   = RUN;
                        end
                        OP_MADDU: begin
                            pend_n    = madd_u;
                            pend_wr_n = 1'b1;
                            cnt_n     = MULT_LAST;
                            state_n   = RUN;
                        end
`endif
                        default: ;
                    endcase
                end
            end

            RUN: begin
                // start is deliberately ignored here; the hazard unit holds the instruction.
                if (cnt == '0) begin
                    state_n = IDLE;
                    if (pend_wr) begin
                        hi_n = pend[63:32];
                        lo_n = pend[31:0];
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end

            default: state_n = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State and architectural registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            pend    <= '0;
            pend_wr <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            pend    <= pend_n;
            pend_wr <= pend_wr_n;
            hi      <= hi_n;
            lo      <= lo_n;
        end
    end

    assign busy     = (state == RUN);
    assign hilo_out = rd_hi ? hi : lo;

endmodule

// File: tb/tb_e_muldiv_unit.sv
// Directed bench for e_muldiv_unit: scoreboarded HI/LO results, busy-length checks, MT/ignore/reset cases.
// Honours MULDIV_MADD_EN the same way the design does.
module tb_e_muldiv_unit;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] rs_data, rt_data;
    logic        rd_hi;
    logic        busy;
    logic [31:0] hi, lo, hilo_out;

    e_muldiv_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .rd_hi    (rd_hi),
        .busy     (busy),
        .hi       (hi),
        .lo       (lo),
        .hilo_out (hilo_out)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    logic [63:0] sb[$];
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Reference behaviour, computed with 64-bit native arithmetic.
    task automatic model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [63:0] e, output int c);
        longint sa, sb_, q, r;
        logic [63:0] ua, ub;
        sa = longint'($signed(a));
        sb_ = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        e = {m_hi, m_lo};
        c = 0;
        case (o)
            4'd1: begin e = 64'(sa * sb_); c = MULT_N; end
            4'd2: begin e = ua * ub;       c = MULT_N; end
            4'd3: begin
                c = DIV_N;
                if (b != 0) begin
                    q = sa / sb_;
                    r = sa % sb_;
                    e = {r[31:0], q[31:0]};
                end
            end
            4'd4: begin
                c = DIV_N;
                if (b != 0) e = {32'(ua % ub), 32'(ua / ub)};
            end
            4'd5: e = {a, m_lo};
            4'd6: e = {m_hi, b == b ? a : a};
`ifdef MULDIV_MADD_EN
            4'd7: begin e = {m_hi, m_lo} + 64'(sa * sb_); c = MULT_N; end
            4'd8: begin e = {m_hi, m_lo} + ua * ub;       c = MULT_N; end
`endif
            default: ;
        endcase
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] e, got;
        int ec, n;
        model(o, a, b, e, ec);
        sb.push_back(e);
        @(negedge clk);
        start = 1'b1; op = o; rs_data = a; rt_data = b;
        @(negedge clk);
        start = 1'b0; op = 4'd0;
        wait_idle(n);
        check({tag, " busy_cycles"}, 64'(n), 64'(ec));
        got = sb.pop_front();
        check({tag, " hi"}, {32'b0, hi}, {32'b0, got[63:32]});
        check({tag, " lo"}, {32'b0, lo}, {32'b0, got[31:0]});
        rd_hi = 1'b0;
        #1 check({tag, " hilo_out lo"}, {32'b0, hilo_out}, {32'b0, got[31:0]});
        rd_hi = 1'b1;
        #1 check({tag, " hilo_out hi"}, {32'b0, hilo_out}, {32'b0, got[63:32]});
        rd_hi = 1'b0;
        m_hi = got[63:32];
        m_lo = got[31:0];
    endtask

    initial begin
        logic [63:0] e, got;
        int ec, n;

        reset = 1'b1; start = 1'b0; op = 4'd0; rs_data = '0; rt_data = '0; rd_hi = 1'b0;
        repeat (2) @(negedge clk);
        check("reset busy", {63'b0, busy}, 64'd0);
        check("reset hi", {32'b0, hi}, 64'd0);
        check("reset lo", {32'b0, lo}, 64'd0);
        reset = 1'b0;

        // Multiply
        run_op("MULT -2*3", 4'd1, 32'hFFFF_FFFE, 32'd3);
        check("MULT spec hi", {32'b0, hi}, 64'h0000_0000_FFFF_FFFF);
        check("MULT spec lo", {32'b0, lo}, 64'h0000_0000_FFFF_FFFA);
        run_op("MULTU 0xFFFFFFFE*3", 4'd2, 32'hFFFF_FFFE, 32'd3);
        check("MULTU spec hi", {32'b0, hi}, 64'h0000_0000_0000_0002);
        run_op("MULT big", 4'd1, 32'h8000_0000, 32'h8000_0000);

        // Divide
        run_op("DIV -7/2", 4'd3, 32'hFFFF_FFF9, 32'd2);
        check("DIV spec lo", {32'b0, lo}, 64'h0000_0000_FFFF_FFFD);
        check("DIV spec hi", {32'b0, hi}, 64'h0000_0000_FFFF_FFFF);
        run_op("DIVU 7/2", 4'd4, 32'd7, 32'd2);
        run_op("DIV min/-1", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        check("DIV min/-1 lo", {32'b0, lo}, 64'h0000_0000_8000_0000);
        run_op("DIV 7/-2", 4'd3, 32'd7, 32'hFFFF_FFFE);
        run_op("DIVU big", 4'd4, 32'hFFFF_FFF9, 32'd2);

        // Divide by zero leaves HI/LO untouched
        run_op("MTHI 0x11", 4'd5, 32'h11, 32'd0);
        run_op("MTLO 0x22", 4'd6, 32'h22, 32'd0);
        run_op("DIVU 5/0", 4'd4, 32'd5, 32'd0);
        check("div0 hi kept", {32'b0, hi}, 64'h11);
        check("div0 lo kept", {32'b0, lo}, 64'h22);
        run_op("DIV -5/0", 4'd3, 32'hFFFF_FFFB, 32'd0);

        // Back-to-back MTHI / MTLO, no busy
        @(negedge clk);
        start = 1'b1; op = 4'd5; rs_data = 32'hDEAD_BEEF;
        @(negedge clk);
        check("MTHI b2b busy", {63'b0, busy}, 64'd0);
        check("MTHI b2b hi", {32'b0, hi}, 64'hDEAD_BEEF);
        op = 4'd6; rs_data = 32'h1234;
        @(negedge clk);
        start = 1'b0; op = 4'd0;
        check("MTLO b2b busy", {63'b0, busy}, 64'd0);
        rd_hi = 1'b1;
        #1 check("MFHI b2b", {32'b0, hilo_out}, 64'hDEAD_BEEF);
        rd_hi = 1'b0;
        #1 check("MFLO b2b", {32'b0, hilo_out}, 64'h1234);
        m_hi = 32'hDEAD_BEEF; m_lo = 32'h1234;

        // op 0 and undefined opcodes do nothing
        run_op("op0", 4'd0, 32'h5555, 32'h7);
        run_op("op9", 4'd9, 32'h5555, 32'h7);
        run_op("op15", 4'd15, 32'h5555, 32'h7);

        // Starts during RUN are ignored
        model(4'd1, 32'h10, 32'h20, e, ec);
        sb.push_back(e);
        @(negedge clk);
        start = 1'b1; op = 4'd1; rs_data = 32'h10; rt_data = 32'h20;
        @(negedge clk);
        start = 1'b0; op = 4'd0;
        check("ign busy c1", {63'b0, busy}, 64'd1);
        @(negedge clk);
        start = 1'b1; op = 4'd6; rs_data = 32'h0BAD;
        check("ign busy c2", {63'b0, busy}, 64'd1);
        @(negedge clk);
        op = 4'd1; rs_data = 32'h7; rt_data = 32'h7;
        check("ign busy c3", {63'b0, busy}, 64'd1);
        @(negedge clk);
        start = 1'b0; op = 4'd0;
        check("ign lo untouched", {32'b0, lo}, 64'h1234);
        wait_idle(n);
        check("ign remaining busy", 64'(n), 64'(MULT_N - 3));
        got = sb.pop_front();
        check("ign hi", {32'b0, hi}, {32'b0, got[63:32]});
        check("ign lo", {32'b0, lo}, {32'b0, got[31:0]});
        m_hi = got[63:32]; m_lo = got[31:0];
        repeat (3) @(negedge clk);
        check("ign no restart", {63'b0, busy}, 64'd0);

        // Reset mid-RUN discards the pending result
        @(negedge clk);
        start = 1'b1; op = 4'd1; rs_data = 32'h3; rt_data = 32'h3;
        @(negedge clk);
        start = 1'b0; op = 4'd0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst mid busy", {63'b0, busy}, 64'd0);
        check("rst mid hi", {32'b0, hi}, 64'd0);
        check("rst mid lo", {32'b0, lo}, 64'd0);
        repeat (8) @(negedge clk);
        check("rst no late write", {hi, lo}, 64'd0);
        check("rst stays idle", {63'b0, busy}, 64'd0);
        m_hi = '0; m_lo = '0;

        // MADD/MADDU (or no-ops when the feature is built out)
        run_op("MTHI 0", 4'd5, 32'h0, 32'd0);
        run_op("MTLO ffff", 4'd6, 32'hFFFF_FFFF, 32'd0);
        run_op("MADDU 1*1", 4'd8, 32'd1, 32'd1);
`ifdef MULDIV_MADD_EN
        check("MADDU spec", {hi, lo}, 64'h0000_0001_0000_0000);
`else
        check("MADDU off", {hi, lo}, 64'h0000_0000_FFFF_FFFF);
`endif
        run_op("MADD -1*1", 4'd7, 32'hFFFF_FFFF, 32'd1);
        run_op("MADD wrap", 4'd7, 32'h8000_0000, 32'h7FFF_FFFF);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
